sequenciador_execucao: RTL and testbench

SEQUENCIADOR_EXECUCAO -- requirements
Module: sequenciador_execucao

---
 rtl/sequenciador_execucao_pkg.sv | 31 +++
 rtl/sequenciador_execucao_detector_borda.sv | 25 ++
 rtl/sequenciador_execucao.sv | 133 +++++++++++++
 tb/tb_sequenciador_execucao.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_execucao_pkg.sv
// Shared phase codes for the execution sequencer and the datapath units.
// The datapath decodes these 4-bit values, so the numeric codes are fixed:
// IF=0, ID=1, EX=2, MEM=3, WB=4, ESP_EX=5, ESP_WB=6, SUMPC=8, FIM=9, PAUSA=10.
// Also holds the wait-cycle limits and the saturating counter helper.
package pkg_estados;

  typedef enum logic [3:0] {
    StIf    = 4'd0,
    StId    = 4'd1,
    StEx    = 4'd2,
    StMem   = 4'd3,
    StWb    = 4'd4,
    StEspEx = 4'd5,
    StEspWb = 4'd6,
    StSumpc = 4'd8,
    StFim   = 4'd9,
    StPausa = 4'd10
  } estado_t;

  // Wait-cycle limits for the EX->MEM and WB->SUMPC stretches.
  localparam int unsigned DELAY_MIN = 0;
  localparam int unsigned DELAY_MAX = 7;

  localparam logic [15:0] CONT_MAX = 16'hFFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] inc_sat(input logic [15:0] v);
    return (v == CONT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sequenciador_execucao_detector_borda.sv
// Rising-edge detector for an already synchronised level.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   sinal    : input level, registered every cycle
//   borda    : 1 in the cycle where sinal is 1 and was 0 on the previous cycle
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic sinal,
  output logic borda
);

  logic sinal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sinal_q <= 1'b0;
    end else begin
      sinal_q <= sinal;
    end
  end

  assign borda = sinal & ~sinal_q;

endmodule

// File: rtl/sequenciador_execucao.sv
// Execution sequencer: walks the datapath through the phases of one instruction
// and broadcasts the phase code on estado. Supports free run, single step,
// a PC breakpoint and a halt on the all-zero instruction.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (reset state is PAUSA)
//   run         : level, 1 = free-running execution
//   step        : synchronised button level; each rising edge in PAUSA runs one instruction
//   brk_en      : breakpoint enable
//   brk_pc      : breakpoint address, compared against pc[7:0]
//   pc          : current PC from the PC-update unit
//   instrucao   : fetched instruction (0 halts in FIM)
//   estado      : phase code for the datapath
//   pausado     : 1 while in PAUSA
//   finalizado  : 1 once FIM is reached
//   cont_instr  : retired instructions, saturating
//   cont_ciclos : active cycles, saturating
module sequenciador_execucao
  import pkg_estados::*;
#(
  parameter int unsigned DELAY_EX = 2,
  parameter int unsigned DELAY_WB = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic        brk_en,
  input  logic [7:0]  brk_pc,
  input  logic [31:0] pc,
  input  logic [31:0] instrucao,
  output logic [3:0]  estado,
  output logic        pausado,
  output logic        finalizado,
  output logic [15:0] cont_instr,
  output logic [15:0] cont_ciclos
);

  // Out-of-range delays are clamped so the 3-bit wait counter stays meaningful.
  localparam int unsigned DelayExLim = (DELAY_EX > DELAY_MAX) ? DELAY_MAX : DELAY_EX;
  localparam int unsigned DelayWbLim = (DELAY_WB > DELAY_MAX) ? DELAY_MAX : DELAY_WB;
  localparam logic [2:0]  EsperaEx   = 3'(DelayExLim);
  localparam logic [2:0]  EsperaWb   = 3'(DelayWbLim);

  estado_t     estado_q, estado_d;
  logic        pausado_q;
  logic        final_q;
  logic [15:0] cont_instr_q;
  logic [15:0] cont_ciclos_q;
  logic        passo_q;   // single-step: pause again after this instruction
  logic        retoma_q;  // resume: skip the breakpoint check on the next IF
  logic [2:0]  espera_q;  // remaining wait cycles in ESP_EX / ESP_WB
  logic        borda_step;
  logic        ciclo_ativo;

  // Only the low byte of pc takes part in the breakpoint compare.
  logic unused_pc_alto;
  assign unused_pc_alto = ^pc[31:8];

  detector_borda u_detector_borda (
    .clk   (clk),
    .rst   (rst),
    .sinal (step),
    .borda (borda_step)
  );

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      StPausa: if (run || borda_step) estado_d = StIf;
      StIf:    estado_d = (brk_en && (pc[7:0] == brk_pc) && !retoma_q) ? StPausa : StId;
      StId:    estado_d = (instrucao == 32'd0) ? StFim : StEx;
      StEx:    estado_d = (EsperaEx == 3'd0) ? StMem : StEspEx;
      StEspEx: estado_d = (espera_q == 3'd0) ? StMem : StEspEx;
      StMem:   estado_d = StWb;
      StWb:    estado_d = (EsperaWb == 3'd0) ? StSumpc : StEspWb;
      StEspWb: estado_d = (espera_q == 3'd0) ? StSumpc : StEspWb;
      StSumpc: estado_d = (passo_q || !run) ? StPausa : StIf;
      StFim:   estado_d = StFim;
      default: estado_d = StPausa;
    endcase
  end

  // Every executing phase is active, and so is the PAUSA cycle that launches
  // an instruction; idling in PAUSA and sitting in FIM are not.
  assign ciclo_ativo = (estado_q != StFim) &&
                       !((estado_q == StPausa) && (estado_d == StPausa));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q      <= StPausa;
      pausado_q     <= 1'b1;
      final_q       <= 1'b0;
      cont_instr_q  <= 16'd0;
      cont_ciclos_q <= 16'd0;
      passo_q       <= 1'b0;
      retoma_q      <= 1'b0;
      espera_q      <= 3'd0;
    end else begin
      estado_q  <= estado_d;
      pausado_q <= (estado_d == StPausa);
      final_q   <= (estado_d == StFim);
      if (ciclo_ativo) begin
        cont_ciclos_q <= inc_sat(cont_ciclos_q);
      end
      case (estado_q)
        StPausa: begin
          if (estado_d == StIf) begin
            retoma_q <= 1'b1;
            // run wins over a simultaneous step edge
            passo_q  <= !run;
          end
        end
        StIf:    retoma_q <= 1'b0;
        StEx:    espera_q <= EsperaEx - 3'd1;
        StEspEx: espera_q <= espera_q - 3'd1;
        StWb:    espera_q <= EsperaWb - 3'd1;
        StEspWb: espera_q <= espera_q - 3'd1;
        StSumpc: begin
          cont_instr_q <= inc_sat(cont_instr_q);
          passo_q      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign estado      = estado_q;
  assign pausado     = pausado_q;
  assign finalizado  = final_q;
  assign cont_instr  = cont_instr_q;
  assign cont_ciclos = cont_ciclos_q;

endmodule

// File: tb/tb_sequenciador_execucao.sv
// Directed bench for sequenciador_execucao with default delays (2/2).
module tb_sequenciador_execucao;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        step;
  logic        brk_en;
  logic [7:0]  brk_pc;
  logic [31:0] pc;
  logic [31:0] instrucao;
  logic [3:0]  estado;
  logic        pausado;
  logic        finalizado;
  logic [15:0] cont_instr;
  logic [15:0] cont_ciclos;

  int n_assert = 0;
  int n_fail   = 0;

  // Free-run phase sequence, one entry per clock after leaving PAUSA.
  logic [3:0] seq_a [11] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd3, 4'd4, 4'd6, 4'd6, 4'd8, 4'd0};

  sequenciador_execucao #(
    .DELAY_EX (2),
    .DELAY_WB (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .step        (step),
    .brk_en      (brk_en),
    .brk_pc      (brk_pc),
    .pc          (pc),
    .instrucao   (instrucao),
    .estado      (estado),
    .pausado     (pausado),
    .finalizado  (finalizado),
    .cont_instr  (cont_instr),
    .cont_ciclos (cont_ciclos)
  );

  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_assert++;
    assert (obs === esp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; brk_en = 1'b0; brk_pc = 8'h00;
    pc = 32'h0; instrucao = 32'h00500093;
    ciclos(2);

    // Reset state
    verifica("rst_estado", estado, 4'd10);
    verifica("rst_pausado", pausado, 1'b1);
    verifica("rst_final", finalizado, 1'b0);
    verifica("rst_instr", cont_instr, 16'd0);
    verifica("rst_ciclos", cont_ciclos, 16'd0);

    // Free run from reset
    rst = 1'b0; run = 1'b1;
    for (int i = 0; i < 11; i++) begin
      ciclos(1);
      verifica($sformatf("seqA[%0d]", i), estado, seq_a[i]);
    end
    verifica("A_instr", cont_instr, 16'd1);
    verifica("A_ciclos", cont_ciclos, 16'd11);
    run = 1'b0;
    ciclos(10);
    verifica("A_stop_pausado", pausado, 1'b1);
    verifica("A_stop_instr", cont_instr, 16'd2);
    verifica("A_stop_ciclos", cont_ciclos, 16'd21);
    ciclos(3);
    verifica("A_idle_ciclos", cont_ciclos, 16'd21);

    // Single step: three pulses, 11 active cycles each
    rst = 1'b1;
    ciclos(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      ciclos(1);
      verifica($sformatf("B_if[%0d]", i), estado, 4'd0);
      step = 1'b0;
      if (i == 2) begin
        // an edge mid-instruction must be discarded
        ciclos(3);
        step = 1'b1;
        ciclos(1);
        step = 1'b0;
        ciclos(6);
      end else begin
        ciclos(10);
      end
      verifica($sformatf("B_pausado[%0d]", i), pausado, 1'b1);
      verifica($sformatf("B_instr[%0d]", i), cont_instr, 16'(i + 1));
      verifica($sformatf("B_ciclos[%0d]", i), cont_ciclos, 16'(11 * (i + 1)));
    end
    ciclos(3);
    verifica("B_no_queue", estado, 4'd10);
    verifica("B_ciclos_end", cont_ciclos, 16'd33);

    // Breakpoint at 0x08
    brk_en = 1'b1; brk_pc = 8'h08; pc = 32'h4; run = 1'b1;
    ciclos(10);
    verifica("C_sumpc", estado, 4'd8);
    pc = 32'h8;
    ciclos(1);
    verifica("C_if", estado, 4'd0);
    run = 1'b0;
    ciclos(1);
    verifica("C_trap", estado, 4'd10);
    verifica("C_trap_pausado", pausado, 1'b1);
    verifica("C_trap_instr", cont_instr, 16'd4);
    verifica("C_trap_ciclos", cont_ciclos, 16'd45);
    ciclos(2);
    verifica("C_hold", estado, 4'd10);
    run = 1'b1;
    ciclos(1);
    verifica("C_resume_if", estado, 4'd0);
    ciclos(1);
    verifica("C_no_retrap", estado, 4'd1);
    run = 1'b0;
    ciclos(9);
    verifica("C_done_pausado", pausado, 1'b1);
    verifica("C_done_instr", cont_instr, 16'd5);
    verifica("C_done_ciclos", cont_ciclos, 16'd56);

    // Halt on instruction 0
    brk_en = 1'b0; instrucao = 32'h0; run = 1'b1;
    ciclos(2);
    verifica("D_id", estado, 4'd1);
    ciclos(1);
    verifica("D_fim", estado, 4'd9);
    verifica("D_final", finalizado, 1'b1);
    verifica("D_pausado", pausado, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run = i[0]; step = ~i[0]; brk_en = 1'b1; brk_pc = pc[7:0];
      ciclos(1);
      verifica($sformatf("D_hold[%0d]", i), estado, 4'd9);
    end
    verifica("D_final_hold", finalizado, 1'b1);
    verifica("D_instr", cont_instr, 16'd5);
    verifica("D_ciclos", cont_ciclos, 16'd59);

    // Reset during ESP_EX
    step = 1'b0; run = 1'b0; brk_en = 1'b0; instrucao = 32'h00500093;
    rst = 1'b1;
    #1;
    verifica("E_rst_fim", estado, 4'd10);
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;
    ciclos(4);
    verifica("E_esp_ex", estado, 4'd5);
    verifica("E_ciclos_pre", cont_ciclos, 16'd4);
    rst = 1'b1;
    #1;
    verifica("E_async_estado", estado, 4'd10);
    verifica("E_async_pausado", pausado, 1'b1);
    verifica("E_async_instr", cont_instr, 16'd0);
    verifica("E_async_ciclos", cont_ciclos, 16'd0);
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    ciclos(3);
    verifica("E_after_estado", estado, 4'd10);
    verifica("E_after_instr", cont_instr, 16'd0);

    // run and step together, counters saturated
    force dut.cont_instr_q = 16'hFFFF;
    force dut.cont_ciclos_q = 16'hFFFF;
    ciclos(1);
    release dut.cont_instr_q;
    release dut.cont_ciclos_q;
    run = 1'b1; step = 1'b1;
    ciclos(1);
    verifica("F_if", estado, 4'd0);
    step = 1'b0;
    ciclos(10);
    verifica("F_freerun", estado, 4'd0);
    verifica("F_instr_sat", cont_instr, 16'hFFFF);
    verifica("F_ciclos_sat", cont_ciclos, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
